fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the rv32i core: owns the program counter, fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake, and presents it to decode with valid/ready. Decode slices `opcode`, `funct_3` and `funct_7` from `instr` for the control unit. Execute redirects the stage on a taken branch or jump.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (word aligned).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction.
- `redirect`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0).
- `instr_valid`  out  1  `instr` holds a valid instruction.
- `instr_ready`  in  1  decode accepts `instr`.
- `instr`  out  32  fetched instruction.
- `instr_pc`  out  32  address of `instr`.
- `instr_pc_plus4`  out  32  `instr_pc + 4` (combinational, mod 2^32).

## Operation
- State machine `fetch_state_t`: IDLE, REQ, WAIT, VALID. Internal regs: `pc`, `kill`.
- IDLE: entered only on reset; next edge -> REQ.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt` -> WAIT, else stay.
- WAIT: on `imem_rvalid`:
  - `kill`=0: capture `imem_rdata` into `instr`, `instr_pc` <= `pc`, `pc` <= `pc`+4 (wraps), -> VALID.
  - `kill`=1: discard data, clear `kill`, -> REQ.
- VALID: `instr_valid`=1; on `instr_ready` -> REQ. `instr`/`instr_pc` stable while unaccepted.
- One outstanding request max; `imem_req`=0 outside REQ.
- Redirect (any state, highest priority): `pc` <= {`redirect_pc`[31:2],2'b00}.
  - IDLE/REQ without `imem_gnt`: -> REQ; address changes next cycle (request may change before grant).
  - REQ with `imem_gnt`: old fetch accepted; -> WAIT, `kill`=1.
  - WAIT without `imem_rvalid`: stay, `kill`=1.
  - WAIT with `imem_rvalid`: data dropped, -> REQ, `kill`=0.
  - VALID: held instruction dropped, -> REQ; a same-cycle `instr_valid`&&`instr_ready` transfer is void (decode squashes too).
- Consecutive redirects: last one wins; `kill` stays set until the single outstanding response returns.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=`RESET_PC`, `pc`=`RESET_PC`, state IDLE, `kill`=0.
- Reset mid-transaction: all state cleared immediately; a late `imem_rvalid` while in IDLE/REQ is ignored.
- First `imem_req` from the first edge after `rst` falls.
- `imem_rvalid` in cycle N -> `instr_valid` from edge N+1.
- Best case (gnt same cycle as req, rvalid next cycle, ready held): one instruction per 3 cycles.
- Redirect in cycle N -> `imem_addr`=new PC from edge N+1 (unless a killed response is pending).
- All outputs registered except `imem_addr` (=`pc`) and `instr_pc_plus4`.

## Structure
- Add to `rv32i_defs`: `fetch_state_t` enum, `NOP_INSTR` = 32'h0000_0013, `XLEN` = 32.
- Single module; no sub-module.

## Test plan
- Reset release, memory grants immediately, rvalid +1, ready=1 -> fetches 0x0, 0x4, 0x8 with `instr_valid` every 3rd cycle, `instr_pc_plus4` = `instr_pc`+4.
- `instr_ready`=0 for 5 cycles in VALID -> `instr`/`instr_pc` stable, `imem_req`=0 throughout.
- Redirect to 0x0000_0102 while WAIT -> response for old PC discarded, next request `imem_addr`=0x0000_0100, delivered `instr_pc`=0x100.
- Redirect in VALID with `instr_ready`=1 same cycle -> no transfer counted, `instr_valid`=0 next cycle, next fetch at target.
- PC=0xFFFF_FFFC fetched -> next `imem_addr`=0x0000_0000, `instr_pc_plus4`=0x0000_0000.
- Assert `rst` during WAIT, rvalid arrives during reset -> outputs at reset values, first fetch after release at `RESET_PC`.

Source files
------------

// File: rtl/rv32i_defs_pkg.sv
// Shared rv32i core definitions: datapath width, canonical NOP and the
// instruction fetch state encoding.
package rv32i_defs;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs one imem request at a time and
// hands the fetched word to decode over a valid/ready pair.
module fetch_unit
    import rv32i_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,

    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            kill_q;
    logic            imem_req_q;
    logic            instr_valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            fetchAdvance;

    // The PC only advances when a live (not killed) response is captured;
    // a redirect always wins and its low two bits are dropped.
    always_comb begin
        fetchAdvance = (state_q == WAIT) && imem_rvalid && !kill_q && !redirect;
        pc_d         = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~XLEN'(3);
        end else if (fetchAdvance) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    // A redirect on the grant cycle still lets the old fetch
                    // go out, so its response must be discarded later.
                    if (imem_gnt) begin
                        state_q    <= WAIT;
                        imem_req_q <= 1'b0;
                        kill_q     <= redirect;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect || kill_q) begin
                            state_q    <= REQ;
                            imem_req_q <= 1'b1;
                            kill_q     <= 1'b0;
                        end else begin
                            state_q       <= VALID;
                            instr_valid_q <= 1'b1;
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= pc_q;
                        end
                    end else if (redirect) begin
                        kill_q <= 1'b1;
                    end
                end
                VALID: begin
                    // Decode squashes on redirect too, so a same-cycle
                    // handshake is simply dropped along with the word.
                    if (redirect || instr_ready) begin
                        state_q       <= REQ;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    kill_q        <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_q + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a randomised imem responder plus a
// reference model of the expected in-order instruction stream.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    int          total = 0;
    int          bad = 0;

    // Reference model: the next PC decode must see, plus the memory responder.
    logic [31:0] expPc = RESET_PC;
    int          xferCount = 0;
    bit          lastXfer = 1'b0;
    bit          memBusy = 1'b0;
    logic [31:0] pendAddr = 32'h0;
    int          pendDelay = 0;
    int          gntPct = 100;
    int          delayLo = 0;
    int          delayHi = 0;
    bit          prevHeld = 1'b0;
    logic [31:0] heldInstr = 32'h0;
    logic [31:0] heldPc = 32'h0;
    int          sinceXfer = 0;
    int          maxSince = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle, entered and left at a falling edge: plays the memory,
    // drives decode/execute inputs and scores any instruction handed over.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit g;
        bit rv;
        lastXfer = 1'b0;
        if (prevHeld) begin
            total++;
            if (instr_valid !== 1'b1 || instr !== heldInstr || instr_pc !== heldPc) begin
                bad++;
                $display("[TB] FAIL hold: valid=%b instr=%h pc=%h, required valid=1 instr=%h pc=%h",
                         instr_valid, instr, instr_pc, heldInstr, heldPc);
            end
        end
        if (imem_req === 1'b1) begin
            total++;
            if (memBusy || imem_addr[1:0] !== 2'b00) begin
                bad++;
                $display("[TB] FAIL req_legal: outstanding=%0b addr=%h, required no outstanding and aligned addr",
                         memBusy, imem_addr);
            end
        end
        rv = memBusy && (pendDelay == 0);
        g  = (imem_req === 1'b1) && !memBusy && (int'($urandom_range(99)) < gntPct);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rv ? memWord(pendAddr) : $urandom;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (instr_valid === 1'b1 && rdy && !redir) begin
            lastXfer = 1'b1;
            xferCount++;
            sinceXfer = 0;
            total++;
            if (instr_pc !== expPc || instr !== memWord(expPc) || instr_pc_plus4 !== expPc + 32'd4) begin
                bad++;
                $display("[TB] FAIL transfer: pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                         instr_pc, instr, instr_pc_plus4, expPc, memWord(expPc), expPc + 32'd4);
            end
            expPc = expPc + 32'd4;
        end else begin
            sinceXfer++;
            if (sinceXfer > maxSince) maxSince = sinceXfer;
        end
        if (redir) expPc = {rpc[31:2], 2'b00};
        prevHeld  = (instr_valid === 1'b1) && !rdy && !redir;
        heldInstr = instr;
        heldPc    = instr_pc;
        if (rv) memBusy = 1'b0;
        else if (memBusy) pendDelay--;
        if (g) begin
            memBusy   = 1'b1;
            pendAddr  = imem_addr;
            pendDelay = $urandom_range(delayHi, delayLo);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        memBusy = 1'b0;
        prevHeld = 1'b0;
        expPc = RESET_PC;
        repeat (2) @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RESET_PC ||
            instr !== 32'h0000_0013 || instr_pc !== RESET_PC || instr_pc_plus4 !== RESET_PC + 32'd4) begin
            bad++;
            $display("[TB] FAIL reset_values: req=%b valid=%b addr=%h instr=%h pc=%h pc4=%h, required 0 0 %h 00000013 %h %h",
                     imem_req, instr_valid, imem_addr, instr, instr_pc, instr_pc_plus4,
                     RESET_PC, RESET_PC, RESET_PC + 32'd4);
        end
        rst = 1'b0;
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL first_req: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_throughput;
        int hits[$];
        gntPct = 100; delayLo = 0; delayHi = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (lastXfer) hits.push_back(i);
        end
        total++;
        if (hits.size() != 3 || hits[0] != 2 || hits[1] != 5 || hits[2] != 8) begin
            bad++;
            $display("[TB] FAIL throughput: %0d transfers in 9 cycles, required 3 at cycles 2,5,8", hits.size());
        end
    endtask

    task automatic test_stall;
        gntPct = 100; delayLo = 0; delayHi = 0;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step(1'b0, 1'b0, 32'h0);
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_reach: valid=%b, required 1 within 20 cycles", instr_valid);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (imem_req !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_req: req=%b in stall cycle %0d, required 0", imem_req, i);
            end
            step(1'b0, 1'b0, 32'h0);
        end
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (!lastXfer) begin
            bad++;
            $display("[TB] FAIL stall_release: transfer=0, required 1");
        end
    endtask

    task automatic test_redirect_wait;
        bit seenReq;
        bit done;
        seenReq = 1'b0;
        done = 1'b0;
        gntPct = 100; delayLo = 2; delayHi = 2;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0102);
        for (int i = 0; i < 30 && !done; i++) begin
            if (imem_req === 1'b1 && !seenReq) begin
                seenReq = 1'b1;
                total++;
                if (imem_addr !== 32'h0000_0100) begin
                    bad++;
                    $display("[TB] FAIL redir_wait_addr: addr=%h, required 00000100", imem_addr);
                end
            end
            if (instr_valid === 1'b1) begin
                done = 1'b1;
                total++;
                if (instr_pc !== 32'h0000_0100) begin
                    bad++;
                    $display("[TB] FAIL redir_wait_pc: pc=%h, required 00000100", instr_pc);
                end
            end
            step(1'b1, 1'b0, 32'h0);
        end
        total++;
        if (!done || !seenReq) begin
            bad++;
            $display("[TB] FAIL redir_wait_progress: delivered=%0b requested=%0b, required 1 1", done, seenReq);
        end
    endtask

    task automatic test_redirect_valid;
        gntPct = 100; delayLo = 0; delayHi = 0;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0200);
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            bad++;
            $display("[TB] FAIL redir_valid: valid=%b req=%b addr=%h, required 0 1 00000200",
                     instr_valid, imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step(1'b0, 1'b0, 32'h0);
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0200) begin
            bad++;
            $display("[TB] FAIL redir_valid_pc: valid=%b pc=%h, required 1 00000200", instr_valid, instr_pc);
        end
        step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_wrap;
        gntPct = 100; delayLo = 0; delayHi = 0;
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step(1'b0, 1'b0, 32'h0);
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc_plus4 !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL wrap_pc: valid=%b pc=%h pc4=%h, required 1 fffffffc 00000000",
                     instr_valid, instr_pc, instr_pc_plus4);
        end
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL wrap_next: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_midwait;
        gntPct = 100; delayLo = 3; delayHi = 3;
        step(1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RESET_PC ||
            instr !== 32'h0000_0013 || instr_pc !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL async_reset: req=%b valid=%b addr=%h instr=%h pc=%h, required reset values",
                     imem_req, instr_valid, imem_addr, instr, instr_pc);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
            bad++;
            $display("[TB] FAIL reset_rvalid: req=%b valid=%b instr=%h, required 0 0 00000013",
                     imem_req, instr_valid, instr);
        end
        rst = 1'b0;
        memBusy = 1'b0;
        prevHeld = 1'b0;
        expPc = RESET_PC;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL late_rvalid: req=%b addr=%h valid=%b, required 1 %h 0",
                         imem_req, imem_addr, instr_valid, RESET_PC);
            end
        end
        imem_rvalid = 1'b0;
        delayLo = 0; delayHi = 1;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step(1'b0, 1'b0, 32'h0);
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== memWord(RESET_PC)) begin
            bad++;
            $display("[TB] FAIL reset_refetch: valid=%b pc=%h instr=%h, required 1 %h %h",
                     instr_valid, instr_pc, instr, RESET_PC, memWord(RESET_PC));
        end
        step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_random;
        int startX;
        gntPct = 60; delayLo = 0; delayHi = 3;
        startX = xferCount;
        sinceXfer = 0;
        maxSince = 0;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(3) != 0, $urandom_range(99) < 8, $urandom);
        end
        total++;
        if (xferCount - startX < 100 || maxSince > 300) begin
            bad++;
            $display("[TB] FAIL random_progress: transfers=%0d longest_gap=%0d, required >=100 and <=300",
                     xferCount - startX, maxSince);
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_stall();
        test_redirect_wait();
        test_redirect_valid();
        test_wrap();
        test_reset_midwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
